// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter and fixed-latency
// sequencer for a single memory port. Requester 0 is the processor,
// requester 1 the program loader / DMA engine.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 26,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ0,
   input  logic              REQ1,
   input  logic              WE0,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] WDATA0,
   input  logic [DATA_W-1:0] WDATA1,
   output logic              GNT0,
   output logic              GNT1,
   output logic              ACK0,
   output logic              ACK1,
   output logic [DATA_W-1:0] RDATA,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_DATA_OUT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   input  logic [DATA_W-1:0] MEM_DATA_IN
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;   // requester served most recently
   logic              win_q, win_d;     // requester owning the current access
   logic              we_q, we_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] mdout_q, mdout_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              sel_c;

   // Winner selection: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      sel_c = 1'b0;
      if (REQ0 && REQ1) begin
         sel_c = ~last_q;
      end else begin
         sel_c = REQ1;
      end
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      win_d   = win_q;
      we_d    = we_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      rd_d    = rd_q;
      wr_d    = wr_q;
      maddr_d = maddr_q;
      mdout_d = mdout_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (REQ0 || REQ1) begin
               win_d   = sel_c;
               we_d    = sel_c ? WE1 : WE0;
               maddr_d = sel_c ? ADDR1 : ADDR0;
               mdout_d = sel_c ? WDATA1 : WDATA0;
               gnt0_d  = ~sel_c;
               gnt1_d  = sel_c;
               rd_d    = ~(sel_c ? WE1 : WE0);
               wr_d    = sel_c ? WE1 : WE0;
               cnt_d   = CNT_LOAD;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               rd_d   = 1'b0;
               wr_d   = 1'b0;
               ack0_d = ~win_q;
               ack1_d = win_q;
               if (!we_q) begin
                  rdata_d = MEM_DATA_IN;
               end
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            last_d  = win_q;
            state_d = S_IDLE;
         end
         default: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access without an ACK.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         maddr_q <= '0;
         mdout_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         win_q   <= win_d;
         we_q    <= we_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         maddr_q <= maddr_d;
         mdout_q <= mdout_d;
         rdata_q <= rdata_d;
      end
   end

   assign GNT0         = gnt0_q;
   assign GNT1         = gnt1_q;
   assign ACK0         = ack0_q;
   assign ACK1         = ack1_q;
   assign RDATA        = rdata_q;
   assign MEM_ADDR     = maddr_q;
   assign MEM_DATA_OUT = mdout_q;
   assign MEM_READ     = rd_q;
   assign MEM_WRITE    = wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with MEM_LAT 2, 1 and 15
// share stimulus; each step checks one instance against hand-derived values.
module tb_mem_port_arbiter;

   logic        CLK;
   logic        RST;
   logic        REQ0, REQ1, WE0, WE1;
   logic [25:0] ADDR0, ADDR1;
   logic [31:0] WDATA0, WDATA1, MEM_DATA_IN;

   logic        gnt0 [3];
   logic        gnt1 [3];
   logic        ack0 [3];
   logic        ack1 [3];
   logic        mrd  [3];
   logic        mwr  [3];
   logic [31:0] rdata [3];
   logic [25:0] maddr [3];
   logic [31:0] mdout [3];

   int npass = 0;
   int nchk  = 0;
   int cyc   = 0;
   int ack_cyc = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_port_arbiter #(
         .ADDR_W (26),
         .DATA_W (32),
         .MEM_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 15))
      ) u_dut (
         .CLK         (CLK),
         .RST         (RST),
         .REQ0        (REQ0),
         .REQ1        (REQ1),
         .WE0         (WE0),
         .WE1         (WE1),
         .ADDR0       (ADDR0),
         .ADDR1       (ADDR1),
         .WDATA0      (WDATA0),
         .WDATA1      (WDATA1),
         .GNT0        (gnt0[g]),
         .GNT1        (gnt1[g]),
         .ACK0        (ack0[g]),
         .ACK1        (ack1[g]),
         .RDATA       (rdata[g]),
         .MEM_ADDR    (maddr[g]),
         .MEM_DATA_OUT(mdout[g]),
         .MEM_READ    (mrd[g]),
         .MEM_WRITE   (mwr[g]),
         .MEM_DATA_IN (MEM_DATA_IN)
      );
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic reset_dut();
      RST  = 1'b0;
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      step();
      step();
      RST = 1'b1;
   endtask

   task automatic chk_zero(input int inst, input string tag);
      chk({tag, "_ctl"}, 64'({gnt0[inst], gnt1[inst], ack0[inst], ack1[inst], mrd[inst], mwr[inst]}), 64'd0);
      chk({tag, "_bus"}, 64'({maddr[inst], mdout[inst]}), 64'd0);
      chk({tag, "_rdata"}, 64'(rdata[inst]), 64'd0);
   endtask

   // One complete access by requester rq on instance inst, REQ dropped on ACK.
   task automatic access(input int inst, input int rq, input int lat, input logic we,
                         input logic [25:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input string tag);
      int strobes, ack_at, bus_bad, other_bad;
      logic own_ack, strobe, other_strobe, other_side;
      strobes = 0; ack_at = -1; bus_bad = 0; other_bad = 0;
      if (rq == 0) begin
         WE0 = we; ADDR0 = addr; WDATA0 = wd; REQ0 = 1'b1;
      end else begin
         WE1 = we; ADDR1 = addr; WDATA1 = wd; REQ1 = 1'b1;
      end
      for (int i = 1; i <= 40; i++) begin
         step();
         strobe       = we ? mwr[inst] : mrd[inst];
         other_strobe = we ? mrd[inst] : mwr[inst];
         other_side   = (rq == 0) ? (gnt1[inst] | ack1[inst]) : (gnt0[inst] | ack0[inst]);
         own_ack      = (rq == 0) ? ack0[inst] : ack1[inst];
         if (strobe === 1'b1) begin
            strobes++;
            if (maddr[inst] !== addr || mdout[inst] !== wd) bus_bad++;
         end
         if (other_strobe !== 1'b0) other_bad++;
         if (other_side !== 1'b0) other_bad++;
         if (own_ack === 1'b1) begin
            ack_at  = i;
            ack_cyc = cyc;
            chk({tag, "_rdata"}, 64'(rdata[inst]), 64'(exp_rd));
            REQ0 = (rq == 0) ? 1'b0 : REQ0;
            REQ1 = (rq == 1) ? 1'b0 : REQ1;
            break;
         end
      end
      chk({tag, "_ack_at"}, 64'(ack_at), 64'(lat + 1));
      chk({tag, "_strobe_width"}, 64'(strobes), 64'(lat));
      chk({tag, "_bus_stable"}, 64'(bus_bad), 64'd0);
      chk({tag, "_exclusive"}, 64'(other_bad), 64'd0);
      step();
      chk({tag, "_idle_after"}, 64'({gnt0[inst], gnt1[inst], ack0[inst], ack1[inst]}), 64'd0);
   endtask

   initial begin
      int a0, a1, a2, nack, dbl, ackw, spur;
      logic [3:0] order;
      logic prev_ack;

      RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
      ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0; MEM_DATA_IN = '0;

      // Reset state
      step();
      chk_zero(0, "reset");
      step();
      RST = 1'b1;

      // Single read, MEM_LAT=2
      MEM_DATA_IN = 32'hDEADBEEF;
      access(0, 0, 2, 1'b0, 26'h0000010, 32'h0, 32'hDEADBEEF, "read");

      // Write from requester 1, RDATA keeps the earlier read value
      MEM_DATA_IN = 32'h0BADF00D;
      access(0, 1, 2, 1'b1, 26'h3FFFFFF, 32'h12345678, 32'hDEADBEEF, "write");

      // Contention from reset release: order 0,1,0,1
      reset_dut();
      WE0 = 1'b0; WE1 = 1'b0; ADDR0 = 26'h1; ADDR1 = 26'h2;
      REQ0 = 1'b1; REQ1 = 1'b1;
      nack = 0; dbl = 0; ackw = 0; order = '0; prev_ack = 1'b0;
      for (int i = 0; i < 60 && nack < 4; i++) begin
         step();
         if (gnt0[0] && gnt1[0]) dbl++;
         if (ack0[0] && ack1[0]) dbl++;
         if (ack0[0] || ack1[0]) begin
            if (prev_ack) ackw++;
            order = {order[2:0], ack1[0]};
            nack++;
         end
         prev_ack = ack0[0] | ack1[0];
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      chk("cont_acks", 64'(nack), 64'd4);
      chk("cont_order", 64'(order), 64'(4'b0101));
      chk("cont_two_gnt", 64'(dbl), 64'd0);
      chk("cont_ack_width", 64'(ackw), 64'd0);
      step();
      chk("cont_idle", 64'({gnt0[0], gnt1[0], ack0[0], ack1[0]}), 64'd0);

      // Streaming by requester 0: one access per MEM_LAT+2 cycles
      MEM_DATA_IN = 32'h11110001;
      access(0, 0, 2, 1'b0, 26'h100, 32'h0, 32'h11110001, "strm0");
      a0 = ack_cyc;
      MEM_DATA_IN = 32'h11110002;
      access(0, 0, 2, 1'b0, 26'h104, 32'h0, 32'h11110002, "strm1");
      a1 = ack_cyc;
      MEM_DATA_IN = 32'h11110003;
      access(0, 0, 2, 1'b0, 26'h108, 32'h0, 32'h11110003, "strm2");
      a2 = ack_cyc;
      chk("strm_period1", 64'(a1 - a0), 64'd4);
      chk("strm_period2", 64'(a2 - a1), 64'd4);

      // Reset in the second ACCESS cycle; last served is 0 here
      WE0 = 1'b0; ADDR0 = 26'h55; REQ0 = 1'b1;
      step();
      step();
      chk("rst_mid_pre", 64'({gnt0[0], mrd[0]}), 64'(2'b11));
      #2;
      RST = 1'b0;
      #1;
      chk_zero(0, "rst_async");
      REQ0 = 1'b0;
      step();
      step();
      RST = 1'b1;
      spur = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (ack0[0] !== 1'b0 || ack1[0] !== 1'b0) spur++;
      end
      chk("rst_no_ack", 64'(spur), 64'd0);
      REQ0 = 1'b1; REQ1 = 1'b1;
      step();
      chk("rst_tie_winner", 64'({gnt0[0], gnt1[0]}), 64'(2'b10));
      REQ1 = 1'b0;
      a0 = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ack0[0] === 1'b1) begin
            a0 = i;
            break;
         end
      end
      REQ0 = 1'b0;
      chk("rst_tie_done", 64'(a0), 64'd1);
      step();

      // Latency sweep
      reset_dut();
      MEM_DATA_IN = 32'hA5A50015;
      access(2, 0, 15, 1'b0, 26'h2AAAAAA, 32'h0, 32'hA5A50015, "lat15");
      reset_dut();
      MEM_DATA_IN = 32'hA5A50001;
      access(1, 0, 1, 1'b0, 26'h1555555, 32'h0, 32'hA5A50001, "lat1");

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single memory port of the CS147 SEC05 system. It sits between the memory model and two masters: requester 0 (processor) and requester 1 (program loader / DMA). It grants the port round-robin, latches the winning request, and drives READ/WRITE for a fixed memory latency. It returns read data with a one-cycle ACK pulse.

## Interface
- ADDR_W, default 26, address width (matches `ADDRESS_INDEX_LIMIT`+1)
- DATA_W, default 32, data width (matches `DATA_INDEX_LIMIT`+1)
- MEM_LAT, default 2, cycles the memory needs per access; legal range 1..15
- CLK  in  1  system clock; all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- REQ0, REQ1  in  1 each  access request; held high until the matching ACK
- WE0, WE1  in  1 each  1=write, 0=read; sampled only at grant
- ADDR0, ADDR1  in  ADDR_W each  request address; sampled at grant
- WDATA0, WDATA1  in  DATA_W each  write data; sampled at grant
- GNT0, GNT1  out  1 each  requester owns the port (ACCESS and DONE states)
- ACK0, ACK1  out  1 each  one-cycle completion pulse
- RDATA  out  DATA_W  read data; valid in the ACK cycle, held until the next read completes
- MEM_ADDR  out  ADDR_W  memory address
- MEM_DATA_OUT  out  DATA_W  memory write data
- MEM_READ, MEM_WRITE  out  1 each  memory strobes
- MEM_DATA_IN  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any REQ is high, pick the winner. If only one requests, it wins. If both request, the winner is the requester not served last.
  - Priority pointer resets to "last served = 1", so requester 0 wins the first tie.
  - On selecting a winner: latch WE/ADDR/WDATA into MEM_* registers, set the winner's GNT, load the latency counter with MEM_LAT-1, and go to ACCESS.
- ACCESS: assert MEM_READ (WE=0) or MEM_WRITE (WE=1).
  - Decrement the counter each cycle.
  - When the counter is 0: capture MEM_DATA_IN into RDATA (reads only), deassert strobes, and go to DONE.
- DONE: pulse the winner's ACK for one cycle; GNT stays high. Update "last served" to the winner, then go to IDLE.
- MEM_READ and MEM_WRITE are never high together. At most one GNT and at most one ACK are high in any cycle.
- A write leaves RDATA unchanged.
- A REQ deasserted before ACK is a protocol violation. The access completes anyway and ACK still pulses.
- Reset: async assertion of RST=0 forces state IDLE from any state, mid-access included. All outputs go to 0, RDATA=0, counter=0, pointer=1. No ACK is issued for an aborted access.

## Timing
- Request seen high in IDLE at edge k:
  - GNT and strobe high from k+1 through k+MEM_LAT.
  - MEM_ADDR/MEM_DATA_OUT stable over that whole window.
  - ACK high for cycle k+MEM_LAT+1, together with RDATA valid.
  - Back in IDLE at k+MEM_LAT+2.
- Back-to-back throughput: one access per MEM_LAT+2 cycles. The IDLE cycle after DONE is mandatory, so the requester's dropped REQ is seen before re-arbitration.
- Strobes change only on rising CLK edges. MEM_DATA_IN is sampled at the edge ending the last ACCESS cycle.
- RST deassertion is taken at the next rising edge; the first grant can occur at the first edge after release.

## Test plan
- Single read: MEM_LAT=2, REQ0 read at ADDR 0x0000010, memory returns 0xDEADBEEF. Required: MEM_READ high 2 cycles, ACK0 at k+3 with RDATA=0xDEADBEEF, GNT1/ACK1 never high.
- Write: REQ1 write 0x12345678 to 0x3FFFFFF. Required: MEM_WRITE high 2 cycles, MEM_ADDR=0x3FFFFFF, MEM_DATA_OUT=0x12345678, ACK1 pulses, RDATA unchanged.
- Contention: REQ0 and REQ1 both high from reset release and held through 4 accesses. Required: grant order 0,1,0,1; each ACK exactly one cycle; never two GNTs high.
- Single-requester streaming: REQ0 re-raised immediately after each ACK for 3 accesses. Required: each access takes MEM_LAT+2 cycles with one IDLE cycle between.
- Reset mid-access: RST=0 in the second ACCESS cycle. Required: all outputs 0 immediately (asynchronously); no ACK after release; next tie goes to requester 0.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15, one read each. Required: strobe width 1 and 15 cycles, ACK at k+2 and k+16.
